// File: rtl/div_pkg.sv
// Shared definitions for the execute-stage divider (op codes, FSM states).
// XLEN is common with the multiplier unit.
package div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    // funct3[1:0] of the RV32M divide group
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial
// subtract divisor on XLEN+1 bits, keep the difference if non-negative.
// Ports: rem/quo/divisor in, rem_next/quo_next out (purely combinational).
module div_step #(
    parameter int XLEN = div_pkg::XLEN
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;
    logic          fits;

    // rem < divisor holds between steps, so the shifted remainder needs
    // one extra bit and a non-negative difference always fits in XLEN.
    assign trial = {rem, quo[XLEN-1]};
    assign diff  = trial - {1'b0, divisor};
    assign fits  = ~diff[XLEN];

    always_comb begin
        rem_next = trial[XLEN-1:0];
        if (fits) begin
            rem_next = diff[XLEN-1:0];
        end
        quo_next = {quo[XLEN-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), fixed 32-cycle latency.
// Ports: clk, rst_n, start/op/a/b request, kill flush; busy, out_valid, c.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN  = div_pkg::XLEN,
    parameter int CNT_W = div_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] c
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t state;
    div_state_t state_next;

    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  divisor;
    logic [CNT_W-1:0] cnt;
    logic             rem_sel;
    logic             q_neg;
    logic             r_neg;
    logic             div0;
    logic             ovf;

    logic [XLEN-1:0]  rem_next;
    logic [XLEN-1:0]  quo_next;
    logic [XLEN-1:0]  q_fin;
    logic [XLEN-1:0]  r_fin;
    logic [XLEN-1:0]  result;
    logic             accept;
    logic             last;
    logic             sgn;

    assign accept = (state == IDLE) && start && !kill;
    assign last   = (cnt == CNT_W'(XLEN-1));
    assign sgn    = ~op[0];

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start && !kill) state_next = CALC;
            CALC: begin
                if (kill) begin
                    state_next = IDLE;
                end else if (last) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    // With a zero divisor every trial succeeds, so rem ends up holding
    // |a|; re-applying the dividend sign yields a, the required REM result.
    always_comb begin
        q_fin  = q_neg ? -quo_next : quo_next;
        r_fin  = r_neg ? -rem_next : rem_next;
        result = rem_sel ? r_fin : q_fin;
        if (div0) begin
            result = rem_sel ? r_fin : '1;
        end else if (ovf) begin
            result = rem_sel ? '0 : MIN_NEG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            cnt     <= '0;
            rem_sel <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            div0    <= 1'b0;
            ovf     <= 1'b0;
            c       <= '0;
        end else if (accept) begin
            rem     <= '0;
            quo     <= (sgn && a[XLEN-1]) ? -a : a;
            divisor <= (sgn && b[XLEN-1]) ? -b : b;
            cnt     <= '0;
            rem_sel <= op[1];
            q_neg   <= sgn && (a[XLEN-1] ^ b[XLEN-1]);
            r_neg   <= sgn && a[XLEN-1];
            div0    <= (b == '0);
            ovf     <= sgn && (a == MIN_NEG) && (b == '1);
        end else if (state == CALC) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 1'b1;
            if (last && !kill) begin
                c <= result;
            end
        end
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divider; the division counterpart to the pipelined multiplier in the execute stage.
- Implements RV32M DIV, DIVU, REM and REMU with radix-2 restoring division.
- Fixed latency, so the core's stall logic holds the pipeline while busy is high.
- Start/done handshake with the core, plus a kill input for pipeline flushes.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- a  input  XLEN  dividend
- b  input  XLEN  divisor
- kill  input  1  abort the current operation (flush)
- busy  output  1  high in CALC and DONE
- out_valid  output  1  result valid, one-cycle pulse
- c  output  XLEN  quotient or remainder

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0; out_valid=0; c=0; counter=0; internal registers=0.
  - Reset mid-operation discards all progress.
- States and transitions:
  - IDLE→CALC on start=1.
  - CALC→DONE after 32 iterations.
  - DONE→IDLE unconditionally.
  - kill=1 in CALC or DONE forces IDLE next edge; out_valid stays 0 if killed in CALC.
- Accept (edge T0, IDLE & start & !kill):
  - Latch op.
  - Signed ops (op[0]=0): store |a|, |b|, and quotient sign = a[31]^b[31], remainder sign = a[31].
  - Unsigned ops: store a and b directly.
  - Precompute the special-case flags: div0 (b==0) and ovf (signed, a==0x80000000, b==0xFFFFFFFF).
  - counter=0.
- CALC, one iteration per edge:
  - Shift {rem,quo} left 1 bit.
  - Trial subtract rem_shifted - divisor as a 33-bit operation.
  - If the result is non-negative: rem=diff, quo LSB=1; else quo LSB=0.
  - counter++; the 32nd iteration (edge T0+32) moves state to DONE.
- DONE (cycle between edges T0+32 and T0+33):
  - out_valid=1 and c is valid for exactly that cycle.
  - c is registered at edge T0+32; c holds its value until the next result and is don't-care when out_valid=0.
- Fixed latency:
  - out_valid rises 32 edges after accept, including the special cases. The iterations still run, and the result is overridden.
  - Back-to-back: the earliest next start is sampled at edge T0+33 (IDLE); start while busy is ignored.
- Results (RISC-V semantics):
  - div0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - ovf: DIV → 0x80000000; REM → 0.
  - Otherwise signed ops: quotient negated if the quotient sign is set; remainder negated if the remainder sign is set.
  - Remainder sign always follows the dividend; the quotient truncates toward zero.
- Widths:
  - All arithmetic is on unsigned XLEN magnitudes; |0x80000000| = 0x80000000 as unsigned (correct).
  - The trial subtraction is XLEN+1 bits; its sign bit decides the quotient bit.
- Simultaneous events:
  - kill and start both high in IDLE → stay IDLE.
  - kill in DONE → out_valid still 1 this cycle (the edge has already passed); IDLE next.

Decomposition:
- Shared package div_pkg:
  - Op encodings: DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU.
  - State enum: IDLE, CALC, DONE.
  - XLEN constant, shared with the mul unit.
- One natural sub-module, div_step: the combinational single iteration (shift, 33-bit subtract, select). It is reusable if the unit is later moved to radix-4 by instantiating it twice per cycle.

Test Plan:
- DIV a=7, b=0xFFFFFFFE (-2) → c=0xFFFFFFFD (-3) with out_valid exactly 32 edges after start. REM with the same operands → c=1.
- DIVU a=0xFFFFFFFF, b=2 → c=0x7FFFFFFF. REMU with the same operands → c=1. DIV with the same operands (-1/2) → c=0.
- Divide by zero, a=5, b=0:
  - DIV → 0xFFFFFFFF; REM → 5; DIVU → 0xFFFFFFFF; REMU → 5.
  - Latency is still 32 edges.
- Overflow, a=0x80000000, b=0xFFFFFFFF: DIV → 0x80000000; REM → 0; DIVU → 0x00000000 (q=0); REMU → 0x80000000.
- Handshake and kill:
  - Start pulsed at T0, with start held high and different operands through T0+10 → only one out_valid pulse, with the first operands' result.
  - kill at T0+15 → no out_valid; busy=0 at T0+16; a new start at T0+16 completes correctly.
  - rst_n dropped mid-CALC → busy=0 and out_valid=0 immediately.
- Randomised: 1000 operations with random op/a/b (10% b=0, 5% overflow pattern) → every c equals the RISC-V reference model. Run with and without SDF back-annotation.
